// File: rtl/ctrl_pkg.sv
// Shared encodings for the main decoder: ALU/extender codes, opcode classes and the control vector.
// CTRL_ILLEGAL_TRAP_EN adds the illegal flag to the control vector.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_SHR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_ZX8  = 2'b00,
    EXT_SX8  = 2'b01,
    EXT_SX12 = 2'b10,
    EXT_SX20 = 2'b11
  } ext_sel_e;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LOG = 2'b01;
  localparam logic [1:0] OP_MEM = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  localparam logic [1:0] MEM_LDR = 2'b00;
  localparam logic [1:0] MEM_STR = 2'b01;
  localparam logic [1:0] MEM_CMP = 2'b10;
  localparam logic [1:0] LOG_MOV = 2'b11;
  localparam logic [1:0] BR_BL   = 2'b11;

  typedef struct packed {
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic     illegal;
`endif
    logic     immout;
    logic     wmem;
    logic     rmem;
    logic     wreg;
    alu_op_e  alu;
    ext_sel_e ext;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of op/inst/immin into the datapath control vector.
// CTRL_ILLEGAL_TRAP_EN flags the reserved encodings instead of decoding them.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] inst,
  input  logic       immin,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_NOP;
    case (op)
      OP_ALU: begin
        ctrl_o.alu    = alu_op_e'({1'b0, inst});
        ctrl_o.wreg   = 1'b1;
        ctrl_o.immout = immin;
        ctrl_o.ext    = EXT_SX8;
      end
      OP_LOG: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (inst == LOG_MOV && immin == 1'b1) begin
          ctrl_o.illegal = 1'b1;
        end else begin
          ctrl_o.alu    = alu_op_e'({1'b1, inst});
          ctrl_o.wreg   = 1'b1;
          ctrl_o.immout = immin;
          ctrl_o.ext    = EXT_ZX8;
        end
`else
        ctrl_o.alu    = alu_op_e'({1'b1, inst});
        ctrl_o.wreg   = 1'b1;
        ctrl_o.immout = immin;
        ctrl_o.ext    = EXT_ZX8;
`endif
      end
      OP_MEM: begin
        case (inst)
          MEM_LDR: begin
            ctrl_o.rmem   = 1'b1;
            ctrl_o.wreg   = 1'b1;
            ctrl_o.alu    = ALU_ADD;
            ctrl_o.immout = 1'b1;
            ctrl_o.ext    = EXT_SX12;
          end
          MEM_STR: begin
            ctrl_o.wmem   = 1'b1;
            ctrl_o.alu    = ALU_ADD;
            ctrl_o.immout = 1'b1;
            ctrl_o.ext    = EXT_SX12;
          end
          MEM_CMP: begin
            ctrl_o.alu    = ALU_SUB;
            ctrl_o.immout = immin;
            ctrl_o.ext    = EXT_SX8;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            ctrl_o.illegal = (inst == 2'b11);
`endif
          end
        endcase
      end
      OP_BR: begin
        ctrl_o.alu    = ALU_ADD;
        ctrl_o.immout = 1'b1;
        ctrl_o.ext    = EXT_SX20;
        ctrl_o.wreg   = (inst == BR_BL);
      end
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder: combinational decode followed by one output register with flush/stall.
// CTRL_ILLEGAL_TRAP_EN adds the registered illegal output.
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic [1:0] inst,
  input  logic       immin,
  input  logic       stall,
  input  logic       flush,
  output logic       immout,
  output logic       wmem,
  output logic       rmem,
  output logic       wreg,
  output logic [2:0] ALUins,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic [1:0] ExtndSel
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  ctrl_decode u_decode (
    .op     (op),
    .inst   (inst),
    .immin  (immin),
    .ctrl_o (ctrl_d)
  );

  // Decode -> output register; flush beats stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= CTRL_NOP;
    end else if (flush) begin
      ctrl_q <= CTRL_NOP;
    end else if (!stall) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign immout   = ctrl_q.immout;
  assign wmem     = ctrl_q.wmem;
  assign rmem     = ctrl_q.rmem;
  assign wreg     = ctrl_q.wreg;
  assign ALUins   = ctrl_q.alu;
  assign ExtndSel = ctrl_q.ext;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal  = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with an expected-vector queue and an independent decode model.
// Vector layout: {illegal (CTRL_ILLEGAL_TRAP_EN only), immout, wmem, rmem, wreg, ALUins, ExtndSel}.
module tb_control_unit;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam int VW = 10;
`else
  localparam int VW = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] op = 2'b00;
  logic [1:0] inst = 2'b00;
  logic       immin = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       immout, wmem, rmem, wreg;
  logic [2:0] ALUins;
  logic [1:0] ExtndSel;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  logic [VW-1:0] obs;
  logic [VW-1:0] model_q;
  logic [VW-1:0] exp_q[$];
  localparam logic [VW-1:0] NOP = '0;

  int n_assert = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .inst     (inst),
    .immin    (immin),
    .stall    (stall),
    .flush    (flush),
    .immout   (immout),
    .wmem     (wmem),
    .rmem     (rmem),
    .wreg     (wreg),
    .ALUins   (ALUins),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal  (illegal),
`endif
    .ExtndSel (ExtndSel)
  );

  always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign obs = {illegal, immout, wmem, rmem, wreg, ALUins, ExtndSel};
`else
  assign obs = {immout, wmem, rmem, wreg, ALUins, ExtndSel};
`endif

  // Expected vector built field by field from the instruction table
  function automatic logic [VW-1:0] model(input logic [1:0] o, input logic [1:0] i, input logic im);
    logic       ill, imo, wm, rm, wr;
    logic [2:0] alu;
    logic [1:0] ext;
    ill = 1'b0; imo = 1'b0; wm = 1'b0; rm = 1'b0; wr = 1'b0; alu = 3'd0; ext = 2'd0;
    case ({o, i})
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        alu = {1'b0, i}; wr = 1'b1; imo = im; ext = 2'b01;
      end
      4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
        alu = {1'b1, i}; wr = 1'b1; imo = im; ext = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (i == 2'b11 && im) begin
          ill = 1'b1; alu = 3'd0; wr = 1'b0; imo = 1'b0; ext = 2'b00;
        end
`endif
      end
      4'b1000: begin rm = 1'b1; wr = 1'b1; alu = 3'b000; imo = 1'b1; ext = 2'b10; end
      4'b1001: begin wm = 1'b1; alu = 3'b000; imo = 1'b1; ext = 2'b10; end
      4'b1010: begin alu = 3'b001; imo = im; ext = 2'b01; end
      4'b1011: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        ill = 1'b1;
`endif
      end
      4'b1100, 4'b1101, 4'b1110: begin alu = 3'b000; imo = 1'b1; ext = 2'b11; end
      4'b1111: begin alu = 3'b000; imo = 1'b1; ext = 2'b11; wr = 1'b1; end
      default: ;
    endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
    return {ill, imo, wm, rm, wr, alu, ext};
`else
    if (ill) return NOP;
    return {imo, wm, rm, wr, alu, ext};
`endif
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [1:0] o, input logic [1:0] i, input logic im,
                      input logic s, input logic f, input string tag);
    logic [VW-1:0] e;
    @(negedge clk);
    op = o; inst = i; immin = im; stall = s; flush = f;
    if (f)      e = NOP;
    else if (s) e = model_q;
    else        e = model(o, i, im);
    model_q = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, exp_q.pop_front());
  endtask

  initial begin
    model_q = NOP;
    // Reset held low with a live ALU-immediate instruction on the inputs
    #3;
    check("reset_async", NOP);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", NOP);

    @(negedge clk);
    rst = 1'b1;
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "first_decode");
    check("first_decode_const", 9'b1_0_0_1_000_01);

    for (int o = 0; o < 2; o++)
      for (int i = 0; i < 4; i++)
        for (int m = 0; m < 2; m++)
          step(2'(o), 2'(i), 1'(m), 1'b0, 1'b0, $sformatf("alu_op%0d_i%0d_m%0d", o, i, m));

    step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "ldr");
    step(2'b10, 2'b01, 1'b0, 1'b0, 1'b0, "str");
    step(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, "cmp_reg");
    step(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, "cmp_imm");
    step(2'b10, 2'b11, 1'b0, 1'b0, 1'b0, "mem_undef");
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'(i), 1'b0, 1'b0, 1'b0, $sformatf("branch_i%0d", i));

    // Stall holds LDR, flush overrides stall, release resumes decode
    step(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, "stall_load_ldr");
    step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, "stall_hold1");
    step(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, "stall_hold2");
    step(2'b01, 2'b00, 1'b0, 1'b1, 1'b1, "flush_over_stall");
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, "resume_xor");
    check("resume_xor_const", 9'b0_0_0_1_100_00);

    // Inputs change mid-cycle; outputs must not follow until the edge
    @(negedge clk);
    op = 2'b11; inst = 2'b11;
    #1;
    check("no_comb_path", model_q);

    // Reset mid-stall clears the held vector
    step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, "pre_reset_ldr");
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    model_q = NOP;
    check("reset_mid_stall", NOP);
    @(negedge clk);
    rst = 1'b1;
    step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, "after_reset_sub");

    step(2'b01, 2'b11, 1'b1, 1'b0, 1'b0, "mov_imm");
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "add_after");
`ifdef CTRL_ILLEGAL_TRAP_EN
    step(2'b10, 2'b11, 1'b0, 1'b0, 1'b0, "trap_mem_undef");
    check("trap_const", 10'b1_0_0_0_0_000_00);
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, "trap_cleared");
    step(2'b10, 2'b11, 1'b0, 1'b0, 1'b0, "trap_again");
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, "trap_flushed");
`endif

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
